branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter WordSize, default 32, meaning PC/target width.
REQ-002 SHALL have parameter Entries, default 16, meaning table depth; power of two, >=2; IdxBits = log2(Entries).
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have fetch_valid  input  1  lookup request this cycle.
REQ-006 SHALL have fetch_pc  input  WordSize  PC being fetched.
REQ-007 SHALL have upd_valid  input  1  resolved branch update this cycle.
REQ-008 SHALL have upd_pc  input  WordSize  PC of resolved branch.
REQ-009 SHALL have upd_target  input  WordSize  resolved branch target.
REQ-010 SHALL have upd_taken  input  1  actual branch outcome.
REQ-011 SHALL have pred_valid  output  1  prediction outputs valid.
REQ-012 SHALL have pred_taken  output  1  predicted taken, feeds branch control pred_taken.
REQ-013 SHALL have pred_pc  output  WordSize  predicted next PC, feeds branch control pred_pc.
REQ-014 SHALL have pred_hit  output  1  lookup matched a valid entry.

Function
REQ-015 Index SHALL be pc[IdxBits+1:2]; tag SHALL be pc[WordSize-1:IdxBits+2].
REQ-016 Entry SHALL hold valid, tag, target, 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-017 Lookup latency SHALL be exactly 1 cycle: outputs registered on the edge after fetch_valid=1.
REQ-018 pred_valid SHALL equal fetch_valid delayed one cycle; outputs hold last values while pred_valid=0.
REQ-019 pred_hit SHALL be 1 iff indexed entry valid and tags equal.
REQ-020 pred_taken SHALL be pred_hit AND counter[1].
REQ-021 pred_pc SHALL be entry target if pred_taken, else fetch_pc+4 modulo 2^WordSize (wrap at all-ones).
REQ-022 Update hit (valid, tag match): counter SHALL saturate-increment if upd_taken, saturate-decrement otherwise; at 11/00 no change.
REQ-023 Update hit with upd_taken=1 SHALL overwrite target with upd_target.
REQ-024 Update miss with upd_taken=1 SHALL allocate: valid=1, new tag, target=upd_target, counter=10, replacing any occupant.
REQ-025 Update miss with upd_taken=0 SHALL leave table unchanged.
REQ-026 Simultaneous lookup and update, same index: lookup SHALL return pre-update contents (read-before-write).
REQ-027 Update and lookup to different indices in one cycle SHALL both complete with no stall.

Reset
REQ-028 rst=1 at an edge SHALL clear all valid bits and counters to 01; targets/tags don't-care.
REQ-029 During/after reset: pred_valid=0, pred_taken=0, pred_hit=0, pred_pc=0.
REQ-030 fetch_valid or upd_valid asserted with rst=1 SHALL be ignored; reset mid-lookup drops the pending result.

Configuration
REQ-031 Macro BTB_STATS_EN SHALL, when defined, add outputs stat_lookups and stat_hits (32-bit each), counting pred_valid and pred_valid&pred_hit cycles, saturating at all-ones, cleared by rst.
REQ-032 Without BTB_STATS_EN the ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package branch_pkg SHALL hold the 2-bit counter enum, its reset constant (01), allocate constant (10), and the parameterised entry struct fields.
REQ-034 One sub-module sat_counter2 SHALL implement the combinational saturating next-state function; the table stays in branch_target_buffer.

Verification
REQ-035 Reset then lookup fetch_pc=0x100 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_pc=0x104.
REQ-036 Update upd_pc=0x100, upd_target=0x200, taken=1; then lookup 0x100 -> pred_hit=1, pred_taken=1, pred_pc=0x200.
REQ-037 From counter 10, two not-taken updates at 0x100 -> counter 00; lookup 0x100 -> pred_hit=1, pred_taken=0, pred_pc=0x104; third not-taken update leaves 00.
REQ-038 Same-cycle lookup and first taken update at 0x100 -> lookup shows pred_hit=0; lookup next cycle shows hit, pred_pc=0x200.
REQ-039 Entries=16: taken update at 0x140 (same index as 0x100, different tag) evicts entry; lookup 0x100 -> pred_hit=0; lookup fetch_pc=0xFFFFFFFC miss -> pred_pc=0x0.
REQ-040 Assert rst after populated entries -> all subsequent lookups miss; with BTB_STATS_EN stat counters read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch target buffer
package branch_pkg;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WEAK_NT;
  localparam ctr_t CTR_ALLOC = CTR_WEAK_T;

  // Width-independent entry fields; tag and target widths depend on the
  // instance parameters and live alongside this in the table.
  typedef struct packed {
    logic valid;
    ctr_t ctr;
  } entry_state_t;

  function automatic logic ctr_predicts_taken(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - combinational 2-bit saturating counter next state
module sat_counter2
  import branch_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CTR_STRONG_T) nxt = ctr_t'(cur + 2'd1);
    end else begin
      if (cur != CTR_STRONG_NT) nxt = ctr_t'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB, 1-cycle lookup; BTB_STATS_EN adds lookup/hit counters
module branch_target_buffer
  import branch_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int Entries  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid,
  input  logic [WordSize-1:0] fetch_pc,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic [WordSize-1:0] upd_target,
  input  logic                upd_taken,
`ifdef BTB_STATS_EN
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_hits,
`endif
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc,
  output logic                pred_hit
);

  localparam int IdxBits = $clog2(Entries);
  localparam int TagBits = WordSize - IdxBits - 2;

  entry_state_t        state_q  [Entries];
  logic [TagBits-1:0]  tag_q    [Entries];
  logic [WordSize-1:0] target_q [Entries];

  logic [IdxBits-1:0]  fetch_idx;
  logic [TagBits-1:0]  fetch_tag;
  logic                lookup_hit;
  logic                lookup_taken;
  logic [WordSize-1:0] lookup_pc;

  logic [IdxBits-1:0]  upd_idx;
  logic [TagBits-1:0]  upd_tag;
  logic                upd_hit;
  ctr_t                upd_ctr_cur;
  ctr_t                upd_ctr_next;

  assign fetch_idx = fetch_pc[IdxBits+1:2];
  assign fetch_tag = fetch_pc[WordSize-1:IdxBits+2];
  assign upd_idx   = upd_pc[IdxBits+1:2];
  assign upd_tag   = upd_pc[WordSize-1:IdxBits+2];

  // Lookup reads the table as it stands before this edge's update.
  assign lookup_hit   = state_q[fetch_idx].valid && (tag_q[fetch_idx] == fetch_tag);
  assign lookup_taken = lookup_hit && ctr_predicts_taken(state_q[fetch_idx].ctr);
  assign lookup_pc    = lookup_taken ? target_q[fetch_idx] : fetch_pc + WordSize'(4);

  assign upd_hit     = state_q[upd_idx].valid && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_cur = state_q[upd_idx].ctr;

  sat_counter2 u_sat_counter2 (
    .cur   (upd_ctr_cur),
    .taken (upd_taken),
    .nxt   (upd_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        state_q[i].valid <= 1'b0;
        state_q[i].ctr   <= CTR_RESET;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        state_q[upd_idx].ctr <= upd_ctr_next;
      end else if (upd_taken) begin
        state_q[upd_idx].valid <= 1'b1;
        state_q[upd_idx].ctr   <= CTR_ALLOC;
      end
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      target_q[upd_idx] <= upd_target;
      if (!upd_hit) tag_q[upd_idx] <= upd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
      pred_pc    <= '0;
    end else begin
      pred_valid <= fetch_valid;
      if (fetch_valid) begin
        pred_hit   <= lookup_hit;
        pred_taken <= lookup_taken;
        pred_pc    <= lookup_pc;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
    end else if (pred_valid) begin
      if (stat_lookups != '1) stat_lookups <= stat_lookups + 32'd1;
      if (pred_hit && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer with reference model
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        pred_hit;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: one slot per index, holding the resident branch's upper PC bits.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  bit [31:0]   m_target [16];
  int          m_ctr    [16];
  bit          e_valid, e_hit, e_taken;
  bit [31:0]   e_pc;
  longint      e_lookups, e_hits;

  branch_target_buffer #(.WordSize(32), .Entries(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
`ifdef BTB_STATS_EN
    .stat_lookups(stat_lookups),
    .stat_hits   (stat_hits),
`endif
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_pc     (pred_pc),
    .pred_hit    (pred_hit)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, and return 1ns after the edge.
  task automatic step(input bit r, input bit fv, input bit [31:0] fp,
                      input bit uv, input bit [31:0] up, input bit [31:0] ut, input bit tk);
    int fi, ui;
    bit hit;
    rst = r; fetch_valid = fv; fetch_pc = fp;
    upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = tk;
    if (r) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
      e_valid = 0; e_hit = 0; e_taken = 0; e_pc = 0;
      e_lookups = 0; e_hits = 0;
    end else begin
      if (e_valid) begin
        if (e_lookups < 64'hFFFF_FFFF) e_lookups++;
        if (e_hit && e_hits < 64'hFFFF_FFFF) e_hits++;
      end
      fi = int'((fp / 4) % 16);
      e_valid = fv;
      if (fv) begin
        e_hit   = m_valid[fi] && m_tag[fi] == fp / 64;
        e_taken = e_hit && m_ctr[fi] >= 2;
        e_pc    = e_taken ? m_target[fi] : fp + 32'd4;
      end
      if (uv) begin
        ui  = int'((up / 4) % 16);
        hit = m_valid[ui] && m_tag[ui] == up / 64;
        if (hit) begin
          m_ctr[ui] = tk ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                         : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
          if (tk) m_target[ui] = ut;
        end else if (tk) begin
          m_valid[ui] = 1; m_tag[ui] = up / 64; m_target[ui] = ut; m_ctr[ui] = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h100, 1, 32'h100, 32'h200, 1);
    checks++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b000 || pred_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b h=%b t=%b pc=%h expected 0 0 0 00000000",
               pred_valid, pred_hit, pred_taken, pred_pc);
    end
    step(0, 1, 32'h100, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_pending: pred_valid=%b expected 0", pred_valid);
    end
    step(0, 1, 32'h100, 0, 0, 0, 0);
    checks++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b100 || pred_pc !== 32'h104) begin
      failures++;
      $display("FAIL first_lookup: got v=%b h=%b t=%b pc=%h expected 1 0 0 00000104",
               pred_valid, pred_hit, pred_taken, pred_pc);
    end
    step(0, 0, 32'h500, 0, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b0 || pred_pc !== 32'h104) begin
      failures++;
      $display("FAIL hold_when_idle: got v=%b pc=%h expected 0 00000104", pred_valid, pred_pc);
    end
  endtask

  task automatic test_read_before_write();
    step(0, 1, 32'h100, 1, 32'h100, 32'h200, 1);
    checks++;
    if (pred_hit !== 1'b0 || pred_pc !== 32'h104) begin
      failures++;
      $display("FAIL same_cycle_rbw: got h=%b pc=%h expected 0 00000104", pred_hit, pred_pc);
    end
    step(0, 1, 32'h100, 0, 0, 0, 0);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b11 || pred_pc !== 32'h200) begin
      failures++;
      $display("FAIL alloc_hit: got h=%b t=%b pc=%h expected 1 1 00000200", pred_hit, pred_taken, pred_pc);
    end
  endtask

  task automatic test_counter_saturation();
    step(0, 0, 0, 1, 32'h100, 0, 0);
    step(0, 0, 0, 1, 32'h100, 0, 0);
    step(0, 1, 32'h100, 0, 0, 0, 0);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b10 || pred_pc !== 32'h104) begin
      failures++;
      $display("FAIL strong_nt: got h=%b t=%b pc=%h expected 1 0 00000104", pred_hit, pred_taken, pred_pc);
    end
    step(0, 0, 0, 1, 32'h100, 0, 0);
    step(0, 0, 0, 1, 32'h100, 32'h300, 1);
    step(0, 1, 32'h100, 0, 0, 0, 0);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b10 || pred_pc !== 32'h104) begin
      failures++;
      $display("FAIL saturate_low: got h=%b t=%b pc=%h expected 1 0 00000104", pred_hit, pred_taken, pred_pc);
    end
    step(0, 0, 0, 1, 32'h100, 32'h340, 1);
    step(0, 1, 32'h100, 0, 0, 0, 0);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b11 || pred_pc !== 32'h340) begin
      failures++;
      $display("FAIL target_overwrite: got h=%b t=%b pc=%h expected 1 1 00000340", pred_hit, pred_taken, pred_pc);
    end
  endtask

  task automatic test_eviction_and_wrap();
    step(0, 0, 0, 1, 32'h140, 32'h800, 1);
    step(0, 1, 32'h100, 0, 0, 0, 0);
    checks++;
    if (pred_hit !== 1'b0 || pred_pc !== 32'h104) begin
      failures++;
      $display("FAIL evicted_miss: got h=%b pc=%h expected 0 00000104", pred_hit, pred_pc);
    end
    step(0, 1, 32'h140, 1, 32'h108, 32'h900, 1);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b11 || pred_pc !== 32'h800) begin
      failures++;
      $display("FAIL new_occupant: got h=%b t=%b pc=%h expected 1 1 00000800", pred_hit, pred_taken, pred_pc);
    end
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    checks++;
    if (pred_hit !== 1'b0 || pred_pc !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: got h=%b pc=%h expected 0 00000000", pred_hit, pred_pc);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h140, 0, 0, 0, 0);
    checks++;
    if (pred_hit !== 1'b0 || pred_pc !== 32'h144) begin
      failures++;
      $display("FAIL miss_after_reset: got h=%b pc=%h expected 0 00000144", pred_hit, pred_pc);
    end
`ifdef BTB_STATS_EN
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stat_lookups !== 32'h0 || stat_hits !== 32'h0) begin
      failures++;
      $display("FAIL stats_reset: got %0d %0d expected 0 0", stat_lookups, stat_hits);
    end
`endif
  endtask

  task automatic test_random();
    bit [31:0] fp, up;
    for (int n = 0; n < 600; n++) begin
      fp = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
      up = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 40) == 0) fp = 32'hFFFF_FFFC;
      step($urandom_range(0, 80) == 0, $urandom_range(0, 3) != 0, fp,
           $urandom_range(0, 1), up, $urandom, $urandom_range(0, 2) != 0);
      checks++;
      if (pred_valid !== e_valid || pred_hit !== e_hit || pred_taken !== e_taken || pred_pc !== e_pc) begin
        failures++;
        $display("FAIL random_%0d: got v=%b h=%b t=%b pc=%h expected v=%b h=%b t=%b pc=%h",
                 n, pred_valid, pred_hit, pred_taken, pred_pc, e_valid, e_hit, e_taken, e_pc);
      end
`ifdef BTB_STATS_EN
      checks++;
      if (stat_lookups !== e_lookups[31:0] || stat_hits !== e_hits[31:0]) begin
        failures++;
        $display("FAIL random_stats_%0d: got %0d %0d expected %0d %0d",
                 n, stat_lookups, stat_hits, e_lookups, e_hits);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 0; fetch_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    test_reset();
    test_read_before_write();
    test_counter_saturation();
    test_eviction_and_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
